// File: rtl/seq_shift_unit.sv
// Multi-cycle barrel-less shifter: shifts a captured word by up to STEP bits per cycle.
// Define SEQ_SHIFT_ROTATE_EN to make mode 11 a rotate-left; otherwise mode 11 acts as LSL.
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    amt,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ser_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0]       MODE_LSL = 2'b00;
    localparam logic [1:0]       MODE_LSR = 2'b01;
    localparam logic [1:0]       MODE_ASR = 2'b10;
`ifdef SEQ_SHIFT_ROTATE_EN
    localparam logic [1:0]       MODE_ROL = 2'b11;
    localparam logic [AW:0]      WIDTH_A  = (AW+1)'(WIDTH);
`endif
    localparam logic [AW-1:0]    STEP_A   = AW'(STEP);
    localparam logic [AW-1:0]    ONE_A    = AW'(1);
    localparam logic [WIDTH-1:0] ONES     = '1;

    // Handshake: start is sampled only in IDLE (no queueing); done is a
    // one-cycle pulse while in DONE, after which dout holds the result.
    state_t           state, state_d;
    logic [WIDTH-1:0] dout_d;
    logic [AW-1:0]    remaining, remaining_d;
    logic [1:0]       mode_q, mode_d;
    logic             ser_out_d;

    logic [AW-1:0]    step_amt;
    logic [AW-1:0]    msb_idx;
    logic [AW-1:0]    lsb_idx;
    logic [WIDTH-1:0] lsl_res;
    logic [WIDTH-1:0] lsr_res;
    logic [WIDTH-1:0] asr_res;
`ifdef SEQ_SHIFT_ROTATE_EN
    logic [WIDTH-1:0] rol_res;
`endif

    // The final step may be shorter than STEP when the amount is not a multiple.
    always_comb begin
        step_amt = (remaining < STEP_A) ? remaining : STEP_A;
        msb_idx  = AW'(WIDTH - int'(step_amt));
        lsb_idx  = step_amt - ONE_A;
        lsl_res  = (dout << step_amt) | (ser_in ? ~(ONES << step_amt) : '0);
        lsr_res  = (dout >> step_amt) | (ser_in ? ~(ONES >> step_amt) : '0);
        asr_res  = $signed(dout) >>> step_amt;
`ifdef SEQ_SHIFT_ROTATE_EN
        rol_res  = (dout << step_amt) | (dout >> (WIDTH_A - {1'b0, step_amt}));
`endif
    end

    always_comb begin
        state_d     = state;
        dout_d      = dout;
        remaining_d = remaining;
        mode_d      = mode_q;
        ser_out_d   = ser_out;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    dout_d      = din;
                    mode_d      = mode;
                    remaining_d = amt;
                    state_d     = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    // Abort wins over the pending step so dout keeps its partial value.
                    remaining_d = '0;
                    state_d     = IDLE;
                end else begin
                    case (mode_q)
                        MODE_LSR: begin
                            dout_d    = lsr_res;
                            ser_out_d = dout[lsb_idx];
                        end
                        MODE_ASR: begin
                            dout_d    = asr_res;
                            ser_out_d = dout[lsb_idx];
                        end
`ifdef SEQ_SHIFT_ROTATE_EN
                        MODE_ROL: begin
                            dout_d    = rol_res;
                            ser_out_d = dout[msb_idx];
                        end
`endif
                        default: begin
                            dout_d    = lsl_res;
                            ser_out_d = dout[msb_idx];
                        end
                    endcase
                    remaining_d = remaining - step_amt;
                    if (remaining == step_amt) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dout      <= '0;
            remaining <= '0;
            mode_q    <= MODE_LSL;
            ser_out   <= 1'b0;
        end else begin
            state     <= state_d;
            dout      <= dout_d;
            remaining <= remaining_d;
            mode_q    <= mode_d;
            ser_out   <= ser_out_d;
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: one STEP=1 and one STEP=4 instance share the inputs.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ser_in = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  amt = '0;
    logic [1:0]  mode = '0;

    logic        busy1, done1, ser_out1;
    logic [15:0] dout1;
    logic        busy4, done4, ser_out4;
    logic [15:0] dout4;

    int compared = 0;
    int mismatched = 0;
    int done_cyc1, done_cyc4, done_cnt1, done_cnt4, busy_cnt1, busy_cnt4;

`ifdef SEQ_SHIFT_ROTATE_EN
    localparam logic [15:0] ROL_EXP = 16'h3412;
`else
    localparam logic [15:0] ROL_EXP = 16'h3400;
`endif

    seq_shift_unit #(.WIDTH(16), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din), .amt(amt),
        .mode(mode), .ser_in(ser_in), .busy(busy1), .done(done1), .dout(dout1),
        .ser_out(ser_out1)
    );

    seq_shift_unit #(.WIDTH(16), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din), .amt(amt),
        .mode(mode), .ser_in(ser_in), .busy(busy4), .done(done4), .dout(dout4),
        .ser_out(ser_out4)
    );

    always #5 clk = ~clk;

    // Drives one start, then samples 40 negedges; cycle 1 is the negedge right after
    // the start edge. Optional start pulses at cycles pa/pb use a different operand.
    task automatic run_op(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                          input logic s, input int pa, input int pb);
        @(negedge clk);
        din = d; amt = a; mode = m; ser_in = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_cyc1 = 0; done_cyc4 = 0; done_cnt1 = 0; done_cnt4 = 0;
        busy_cnt1 = 0; busy_cnt4 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done1) begin done_cnt1++; if (done_cyc1 == 0) done_cyc1 = c; end
            if (done4) begin done_cnt4++; if (done_cyc4 == 0) done_cyc4 = c; end
            if (busy1) busy_cnt1++;
            if (busy4) busy_cnt4++;
            start = (c == pa) || (c == pb);
            if (start) begin din = 16'hAAAA; amt = 4'd3; end
            if (c < 40) begin @(posedge clk); @(negedge clk); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++; if (dout1 !== 16'h0000) begin mismatched++; $display("FAIL reset_dout1: got %h expected 0000", dout1); end
        compared++; if ({busy1, done1, ser_out1} !== 3'b000) begin mismatched++; $display("FAIL reset_flags1: got %b expected 000", {busy1, done1, ser_out1}); end
        compared++; if ({busy4, done4, ser_out4, dout4} !== 19'h0) begin mismatched++; $display("FAIL reset_u4: got %h expected 0", {busy4, done4, ser_out4, dout4}); end
        rst = 1'b0;
    endtask

    task automatic test_lsl();
        run_op(16'h00F1, 4'd4, 2'b00, 1'b0, 0, 0);
        compared++; if (dout1 !== 16'h0F10) begin mismatched++; $display("FAIL lsl_dout1: got %h expected 0f10", dout1); end
        compared++; if (ser_out1 !== 1'b0) begin mismatched++; $display("FAIL lsl_ser_out1: got %b expected 0", ser_out1); end
        compared++; if (done_cyc1 != 5) begin mismatched++; $display("FAIL lsl_done_cycle1: got %0d expected 5", done_cyc1); end
        compared++; if (done_cnt1 != 1) begin mismatched++; $display("FAIL lsl_done_width1: got %0d expected 1", done_cnt1); end
        compared++; if (done_cyc4 != 2 || dout4 !== 16'h0F10) begin mismatched++; $display("FAIL lsl_u4: got cycle %0d dout %h expected 2 0f10", done_cyc4, dout4); end
    endtask

    task automatic test_asr();
        run_op(16'h8001, 4'd3, 2'b10, 1'b1, 0, 0);
        compared++; if (dout1 !== 16'hF000) begin mismatched++; $display("FAIL asr_dout1: got %h expected f000", dout1); end
        compared++; if (ser_out1 !== 1'b0) begin mismatched++; $display("FAIL asr_ser_out1: got %b expected 0", ser_out1); end
        compared++; if (busy_cnt1 != 4) begin mismatched++; $display("FAIL asr_busy_cycles1: got %0d expected 4", busy_cnt1); end
        compared++; if (done_cyc1 != 4) begin mismatched++; $display("FAIL asr_done_cycle1: got %0d expected 4", done_cyc1); end
        compared++; if (dout4 !== 16'hF000) begin mismatched++; $display("FAIL asr_dout4: got %h expected f000", dout4); end
    endtask

    task automatic test_lsr_multi_step();
        run_op(16'h0000, 4'd5, 2'b01, 1'b1, 0, 0);
        compared++; if (dout4 !== 16'hF800) begin mismatched++; $display("FAIL lsr_dout4: got %h expected f800", dout4); end
        compared++; if (done_cyc4 != 3) begin mismatched++; $display("FAIL lsr_done_cycle4: got %0d expected 3", done_cyc4); end
        compared++; if (busy_cnt4 != 3) begin mismatched++; $display("FAIL lsr_busy_cycles4: got %0d expected 3", busy_cnt4); end
        compared++; if (dout1 !== 16'hF800 || done_cyc1 != 6) begin mismatched++; $display("FAIL lsr_u1: got dout %h cycle %0d expected f800 6", dout1, done_cyc1); end
    endtask

    task automatic test_rotate();
        run_op(16'h1234, 4'd8, 2'b11, 1'b0, 0, 0);
        compared++; if (dout4 !== ROL_EXP) begin mismatched++; $display("FAIL rol_dout4: got %h expected %h", dout4, ROL_EXP); end
        compared++; if (done_cyc4 != 3) begin mismatched++; $display("FAIL rol_done_cycle4: got %0d expected 3", done_cyc4); end
        compared++; if (dout1 !== ROL_EXP || done_cyc1 != 9) begin mismatched++; $display("FAIL rol_u1: got dout %h cycle %0d expected %h 9", dout1, done_cyc1, ROL_EXP); end
    endtask

    task automatic test_fill();
        run_op(16'h8000, 4'd1, 2'b00, 1'b1, 0, 0);
        compared++; if (dout1 !== 16'h0001 || ser_out1 !== 1'b1) begin mismatched++; $display("FAIL lsl_fill: got %h/%b expected 0001/1", dout1, ser_out1); end
        run_op(16'h0005, 4'd1, 2'b01, 1'b0, 0, 0);
        compared++; if (dout1 !== 16'h0002 || ser_out1 !== 1'b1) begin mismatched++; $display("FAIL lsr_out: got %h/%b expected 0002/1", dout1, ser_out1); end
    endtask

    task automatic test_zero_amt();
        run_op(16'hBEEF, 4'd0, 2'b00, 1'b0, 0, 0);
        compared++; if (dout1 !== 16'hBEEF) begin mismatched++; $display("FAIL zero_dout1: got %h expected beef", dout1); end
        compared++; if (done_cyc1 != 1 || done_cyc4 != 1) begin mismatched++; $display("FAIL zero_done_cycle: got %0d/%0d expected 1/1", done_cyc1, done_cyc4); end
        compared++; if (busy_cnt1 != 1) begin mismatched++; $display("FAIL zero_busy_cycles1: got %0d expected 1", busy_cnt1); end
        // ser_out was last set to 1 by the LSR step and must hold with no shift.
        compared++; if (ser_out1 !== 1'b1) begin mismatched++; $display("FAIL zero_ser_out_hold: got %b expected 1", ser_out1); end
    endtask

    task automatic test_busy_ignore();
        // Start pulses land in cycle 3 (SHIFT) and cycle 7 (DONE) of u1.
        run_op(16'h0001, 4'd6, 2'b00, 1'b0, 3, 7);
        compared++; if (dout1 !== 16'h0040) begin mismatched++; $display("FAIL busy_ignore_dout1: got %h expected 0040", dout1); end
        compared++; if (done_cyc1 != 7 || done_cnt1 != 1) begin mismatched++; $display("FAIL busy_ignore_done1: got cycle %0d count %0d expected 7 1", done_cyc1, done_cnt1); end
    endtask

    task automatic test_abort();
        int dseen;
        dseen = 0;
        @(negedge clk);
        din = 16'hFFFF; amt = 4'd8; mode = 2'b00; ser_in = 1'b0; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        compared++; if (busy1 !== 1'b1) begin mismatched++; $display("FAIL start_over_abort: got busy %b expected 1", busy1); end
        // Three full SHIFT cycles, then abort during the next one.
        repeat (3) begin @(posedge clk); @(negedge clk); if (done1) dseen++; end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        if (done1) dseen++;
        compared++; if (busy1 !== 1'b0 || dout1 !== 16'hFFF8) begin mismatched++; $display("FAIL abort_state: got busy %b dout %h expected 0 fff8", busy1, dout1); end
        repeat (5) begin @(posedge clk); @(negedge clk); if (done1) dseen++; end
        compared++; if (dseen != 0 || dout1 !== 16'hFFF8) begin mismatched++; $display("FAIL abort_no_done: got %0d pulses dout %h expected 0 fff8", dseen, dout1); end
    endtask

    task automatic test_reset_mid_shift();
        repeat (20) @(negedge clk);
        din = 16'hFFFF; amt = 4'd8; mode = 2'b00; ser_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        #1;
        compared++; if (dout1 !== 16'h0000 || busy1 !== 1'b0 || done1 !== 1'b0 || ser_out1 !== 1'b0) begin
            mismatched++; $display("FAIL async_reset: got dout %h busy %b done %b ser %b expected 0000 0 0 0", dout1, busy1, done1, ser_out1);
        end
        @(negedge clk);
        rst = 1'b0;
        din = 16'h0003; amt = 4'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        compared++; if (busy1 !== 1'b1) begin mismatched++; $display("FAIL first_start_after_reset: got busy %b expected 1", busy1); end
        @(posedge clk);
        @(negedge clk);
        compared++; if (done1 !== 1'b1 || dout1 !== 16'h0006) begin mismatched++; $display("FAIL post_reset_op: got done %b dout %h expected 1 0006", done1, dout1); end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_asr();
        test_lsr_multi_step();
        test_rotate();
        test_fill();
        test_zero_amt();
        test_busy_ignore();
        test_abort();
        test_reset_mid_shift();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
